// File: rtl/pipe_e2m_stage.sv
// pipe_e2m_stage: elastic EX->MEM pipeline register.
//
// Holds the ALU result, store data, destination register and MEM/WB control bundle
// of one instruction between the execute and memory stages. It has a valid/ready
// handshake on both sides, a synchronous flush, an optional second (skid) entry and
// a saturating stall counter.
//
// Parameters
//   DATA_W  width of ALUResult / WriteData words
//   ADDR_W  width of destination register index
//   CTRL_W  width of control bundle {PCSrc, RegWrite, MemtoReg, MemWrite}
//   SKID    1: two entries, registered readyE; 0: one entry, combinational readyE
//   CNT_W   width of stall counter
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   validE / readyE     EX-side handshake; transfer when both high at posedge
//   ALUResultE, WriteDataE, WA3E, CtrlE   EX-side payload
//   flush               drop every held entry and the input on the next edge
//   validM / readyM     MEM-side handshake; head consumed when both high at posedge
//   ALUOutM, WriteDataM, WA3M, CtrlM      head payload (CtrlM is 0 while validM=0)
//   StallCnt            edges with validM & ~readyM, saturating at all-ones
module pipe_e2m_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              validE,
  output logic              readyE,
  input  logic [DATA_W-1:0] ALUResultE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [ADDR_W-1:0] WA3E,
  input  logic [CTRL_W-1:0] CtrlE,
  input  logic              flush,
  output logic              validM,
  input  logic              readyM,
  output logic [DATA_W-1:0] ALUOutM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [ADDR_W-1:0] WA3M,
  output logic [CTRL_W-1:0] CtrlM,
  output logic [CNT_W-1:0]  StallCnt
);

  localparam int unsigned EntW = 2 * DATA_W + ADDR_W + CTRL_W;

  logic [EntW-1:0]   in_ent;
  logic [EntW-1:0]   head_q, head_d;
  logic [EntW-1:0]   skid_q, skid_d;
  logic              head_vld_q, head_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] head_ctrl;
  logic              accept;
  logic              drain;

  assign in_ent = {ALUResultE, WriteDataE, WA3E, CtrlE};
  assign accept = validE & readyE;
  assign drain  = head_vld_q & readyM;

  // rdy_q is 0 throughout reset and rises on the first edge after release. With a skid
  // entry it simply mirrors "skid slot free", so readyE has no path from readyM.
  assign rdy_d = ~skid_vld_d;

  if (SKID != 0) begin : g_skid
    assign readyE = rdy_q;
  end else begin : g_noskid
    // Single entry: the slot is free now if empty or if the head leaves on this edge.
    assign readyE = rdy_q & (~head_vld_q | readyM);
  end

  // Occupancy: EMPTY (no head), ONE (head only), TWO (head + skid, SKID=1 only).
  always_comb begin
    head_d     = head_q;
    skid_d     = skid_q;
    head_vld_d = head_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      // Payload registers keep stale data; only the valid bits are cleared.
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      // TWO: readyE is low, so only a drain can happen; skid moves up to head.
      if (drain) begin
        head_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (!head_vld_q) begin
      if (accept) begin
        head_d     = in_ent;
        head_vld_d = 1'b1;
      end
    end else begin
      if (accept && drain) begin
        head_d = in_ent;
      end else if (drain) begin
        head_vld_d = 1'b0;
      end else if (accept && (SKID != 0)) begin
        // Head is stalled: park the new entry behind it to keep FIFO order.
        skid_d     = in_ent;
        skid_vld_d = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (head_vld_q && !readyM && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      skid_q     <= '0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign {ALUOutM, WriteDataM, WA3M, head_ctrl} = head_q;
  assign CtrlM    = head_vld_q ? head_ctrl : '0;
  assign validM   = head_vld_q;
  assign StallCnt = cnt_q;

  // Structural invariants of the occupancy encoding.
  a_skid_behind_head : assert property (@(posedge clk) disable iff (!reset)
    skid_vld_q |-> head_vld_q);
  a_noskid_single : assert property (@(posedge clk) disable iff (!reset)
    (SKID == 0) |-> !skid_vld_q);
  a_stall_hold : assert property (@(posedge clk) disable iff (!reset)
    (head_vld_q && !readyM && !flush) |=> (head_vld_q && $stable(head_q)));

endmodule

// File: tb/tb_pipe_e2m_stage.sv
module tb_pipe_e2m_stage;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 4;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] wd;
    logic [AW-1:0] wa;
    logic [CW-1:0] ctrl;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          validE = 1'b0;
  logic          flush = 1'b0;
  logic          readyM = 1'b0;
  logic [DW-1:0] aluE = '0;
  logic [DW-1:0] wdE = '0;
  logic [AW-1:0] waE = '0;
  logic [CW-1:0] ctrlE = '0;

  logic          readyE_w [2];
  logic          validM_w [2];
  logic [DW-1:0] aluM_w   [2];
  logic [DW-1:0] wdM_w    [2];
  logic [AW-1:0] waM_w    [2];
  logic [CW-1:0] ctrlM_w  [2];
  logic [3:0]    cnt0;
  logic [15:0]   cnt1;

  always #5 clk = ~clk;

  // dut0: skid buffer, narrow counter (saturation reachable); dut1: single entry.
  pipe_e2m_stage #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_dut0 (
    .clk(clk), .reset(reset), .validE(validE), .readyE(readyE_w[0]),
    .ALUResultE(aluE), .WriteDataE(wdE), .WA3E(waE), .CtrlE(ctrlE), .flush(flush),
    .validM(validM_w[0]), .readyM(readyM), .ALUOutM(aluM_w[0]), .WriteDataM(wdM_w[0]),
    .WA3M(waM_w[0]), .CtrlM(ctrlM_w[0]), .StallCnt(cnt0)
  );

  pipe_e2m_stage #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_dut1 (
    .clk(clk), .reset(reset), .validE(validE), .readyE(readyE_w[1]),
    .ALUResultE(aluE), .WriteDataE(wdE), .WA3E(waE), .CtrlE(ctrlE), .flush(flush),
    .validM(validM_w[1]), .readyM(readyM), .ALUOutM(aluM_w[1]), .WriteDataM(wdM_w[1]),
    .WA3M(waM_w[1]), .CtrlM(ctrlM_w[1]), .StallCnt(cnt1)
  );

  // Reference model: per DUT a FIFO of accepted entries (capacity 2 or 1), an "out of
  // reset" flag and a plain saturating stall count.
  entry_t q0[$];
  entry_t q1[$];
  int     stall [2];
  bit     armed [2];
  int     n_cmp = 0;
  int     n_err = 0;

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic entry_t qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int d);
    if (d == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic qpush(input int d, input entry_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic qclr(input int d);
    if (d == 0) q0.delete();
    else q1.delete();
  endtask

  task automatic cmp(input int d, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL dut%0d %s: got %0h expected %0h (t=%0t)", d, name, act, exp, $time);
    end
  endtask

  // Checks the visible state against the model, then applies the upcoming edge.
  task automatic mon(input int d);
    int     sz;
    int     maxc;
    bit     exp_rdy;
    entry_t head;
    entry_t in_e;
    logic [15:0] cnt_act;
    sz      = qsize(d);
    maxc    = (d == 0) ? 15 : 65535;
    cnt_act = (d == 0) ? {12'd0, cnt0} : cnt1;
    if (!reset) begin
      qclr(d);
      stall[d] = 0;
      armed[d] = 1'b0;
      cmp(d, "rst_readyE", {63'd0, readyE_w[d]}, 64'd0);
      cmp(d, "rst_validM", {63'd0, validM_w[d]}, 64'd0);
      cmp(d, "rst_ALUOutM", {32'd0, aluM_w[d]}, 64'd0);
      cmp(d, "rst_WriteDataM", {32'd0, wdM_w[d]}, 64'd0);
      cmp(d, "rst_WA3M", {60'd0, waM_w[d]}, 64'd0);
      cmp(d, "rst_CtrlM", {60'd0, ctrlM_w[d]}, 64'd0);
      cmp(d, "rst_StallCnt", {48'd0, cnt_act}, 64'd0);
      return;
    end
    if (d == 0) exp_rdy = armed[d] && (sz < 2);
    else        exp_rdy = armed[d] && ((sz == 0) || readyM);
    cmp(d, "readyE", {63'd0, readyE_w[d]}, {63'd0, exp_rdy});
    cmp(d, "validM", {63'd0, validM_w[d]}, {63'd0, sz > 0});
    if (sz > 0) begin
      head = qfront(d);
      cmp(d, "ALUOutM", {32'd0, aluM_w[d]}, {32'd0, head.alu});
      cmp(d, "WriteDataM", {32'd0, wdM_w[d]}, {32'd0, head.wd});
      cmp(d, "WA3M", {60'd0, waM_w[d]}, {60'd0, head.wa});
      cmp(d, "CtrlM", {60'd0, ctrlM_w[d]}, {60'd0, head.ctrl});
    end else begin
      cmp(d, "CtrlM_idle", {60'd0, ctrlM_w[d]}, 64'd0);
    end
    cmp(d, "StallCnt", {48'd0, cnt_act}, stall[d]);
    // Effect of the coming rising edge.
    armed[d] = 1'b1;
    if (sz > 0 && !readyM && stall[d] < maxc) stall[d]++;
    if (flush) begin
      qclr(d);
    end else begin
      if (sz > 0 && readyM) qpop(d);
      if (validE && exp_rdy) begin
        in_e = '{alu: aluE, wd: wdE, wa: waE, ctrl: ctrlE};
        qpush(d, in_e);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic [DW-1:0] a, input logic rm, input logic fl);
    @(posedge clk);
    #1;
    validE = v;
    aluE   = a;
    wdE    = $urandom;
    waE    = AW'($urandom);
    ctrlE  = CW'($urandom);
    readyM = rm;
    flush  = fl;
  endtask

  initial begin
    // Reset held with validE toggling.
    for (int i = 0; i < 4; i++) cyc(i[0], 32'h1234_0000 + i, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    validE = 1'b0;
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Streaming with readyM high.
    cyc(1'b1, 32'h10, 1'b1, 1'b0);
    cyc(1'b1, 32'h20, 1'b1, 1'b0);
    cyc(1'b1, 32'h30, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Back-pressure: A then B with MEM stalled, then release.
    cyc(1'b1, 32'hAAAA, 1'b0, 1'b0);
    cyc(1'b1, 32'hBBBB, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush while full, with a valid input that must be dropped.
    cyc(1'b1, 32'h1, 1'b0, 1'b0);
    cyc(1'b1, 32'h2, 1'b0, 1'b0);
    cyc(1'b1, 32'h3, 1'b1, 1'b1);
    ctrlE = 4'hF;
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Long stall: dut0's 4-bit counter must saturate and survive a flush.
    cyc(1'b1, 32'h5555, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    cmp(0, "stall_sat", {60'd0, cnt0}, 64'd15);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    cmp(0, "stall_after_flush", {60'd0, cnt0}, 64'd15);

    // Random traffic with occasional flush and asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 29) == 0));
      reset = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
